// File: rtl/sudoku_board_loader.sv
// rtl/sudoku_board_loader.sv - copies one puzzle from the flat puzzle ROM buses into the board RAM write stream
// Optional feature macro: RANDOM_PICK_EN (LFSR-chosen puzzle index instead of puzzle_sel).
module sudoku_board_loader #(
  parameter int NUM_PUZZLES = 15,
  parameter int CELLS       = 81,
  parameter int DIGIT_W     = 4
) (
  input  logic                                  clk,
  input  logic                                  reset,
  input  logic                                  start,
  input  logic                                  abort,
  input  logic [3:0]                            puzzle_sel,
  input  logic [NUM_PUZZLES*CELLS-1:0]          visibilities,
  input  logic [NUM_PUZZLES*CELLS*DIGIT_W-1:0]  maps,
  input  logic                                  wr_ready,
  output logic                                  wr_en,
  output logic [6:0]                            wr_addr,
  output logic [DIGIT_W-1:0]                    wr_digit,
  output logic                                  wr_given,
  output logic                                  busy,
  output logic                                  done,
  output logic                                  sel_err,
  output logic [3:0]                            loaded_idx
);

  localparam int TOTAL = NUM_PUZZLES * CELLS;
  localparam int MAP_W = TOTAL * DIGIT_W;
  localparam int K_W   = $clog2(TOTAL);
  localparam int B_W   = $clog2(MAP_W);

  typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

  state_t           state, state_nxt;
  logic [6:0]       cnt, cnt_nxt;
  logic [3:0]       idx_nxt;
  logic             sel_err_nxt;
  logic [3:0]       pick_idx;
  logic             pick_ok;
  logic [K_W-1:0]   cell_k;
  logic [B_W-1:0]   dig_base;
  logic [K_W-1:0]   vis_pos;
  logic [DIGIT_W-1:0] cell_digit;
  logic             cell_given;

`ifdef RANDOM_PICK_EN
  // x^4+x^3+1 never reaches 0, so lfsr-1 always lands in 0..14.
  logic [3:0] lfsr;
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 4'b0001;
    else       lfsr <= {lfsr[2:0], lfsr[3] ^ lfsr[2]};
  end
  assign pick_idx = lfsr - 4'd1;
  assign pick_ok  = 1'b1;
`else
  assign pick_idx = puzzle_sel;
  assign pick_ok  = puzzle_sel < 4'(NUM_PUZZLES);
`endif

  // Puzzle 0, cell 0 sits in the MSBs of both ROM buses.
  assign cell_k     = K_W'(loaded_idx) * K_W'(CELLS) + K_W'(cnt);
  assign dig_base   = B_W'(MAP_W - 1) - {cell_k, 2'b00};
  assign vis_pos    = K_W'(TOTAL - 1) - cell_k;
  assign cell_digit = maps[dig_base -: DIGIT_W];
  assign cell_given = visibilities[vis_pos];

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 7'd0;
      loaded_idx <= 4'd0;
      sel_err    <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      loaded_idx <= idx_nxt;
      sel_err    <= sel_err_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    idx_nxt     = loaded_idx;
    sel_err_nxt = 1'b0;
    wr_en       = 1'b0;
    wr_addr     = 7'd0;
    wr_digit    = '0;
    wr_given    = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        if (start && !abort) begin
          if (pick_ok) begin
            idx_nxt   = pick_idx;
            cnt_nxt   = 7'd0;
            state_nxt = LOAD;
          end else begin
            sel_err_nxt = 1'b1;
          end
        end
      end
      LOAD: begin
        busy     = 1'b1;
        wr_en    = 1'b1;
        wr_addr  = cnt;
        wr_given = cell_given;
        wr_digit = cell_given ? cell_digit : '0;
        if (wr_ready) begin
          if (cnt == 7'(CELLS - 1)) begin
            cnt_nxt   = 7'd0;
            state_nxt = DONE;
          end else begin
            cnt_nxt = cnt + 7'd1;
          end
        end
        // The write presented this cycle still completes; only the sequence stops.
        if (abort) begin
          cnt_nxt   = 7'd0;
          state_nxt = IDLE;
        end
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_sudoku_board_loader.sv
// tb/tb_sudoku_board_loader.sv - directed self-checking bench for sudoku_board_loader
module tb_sudoku_board_loader;

  logic          clk = 1'b0;
  logic          reset, start, abort, wr_ready;
  logic [3:0]    puzzle_sel;
  logic [1214:0] visibilities;
  logic [4859:0] maps;
  logic          wr_en, wr_given, busy, done, sel_err;
  logic [6:0]    wr_addr;
  logic [3:0]    wr_digit, loaded_idx;

  int checks = 0;
  int errors = 0;

  sudoku_board_loader dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .puzzle_sel(puzzle_sel), .visibilities(visibilities), .maps(maps),
    .wr_ready(wr_ready), .wr_en(wr_en), .wr_addr(wr_addr), .wr_digit(wr_digit),
    .wr_given(wr_given), .busy(busy), .done(done), .sel_err(sel_err),
    .loaded_idx(loaded_idx)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_digit(input int k);
    return 4'((k * 7 + k / 13) % 9 + 1);
  endfunction

  function automatic logic ref_given(input int k);
    return ((k * 5) % 7) < 4;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_wr_en"}, wr_en, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_sel_err"}, sel_err, 0);
    check({tag, "_wr_addr"}, wr_addr, 0);
    check({tag, "_wr_digit"}, wr_digit, 0);
    check({tag, "_wr_given"}, wr_given, 0);
  endtask

  // Start puzzle p; expect 81 in-order writes and done at offset exp_done after the start cycle.
  task automatic run_load(input int p, input bit bp, input int exp_done, input bit poke);
    int  n;
    bit  got_done;
    int  k;
    n = 0;
    got_done = 1'b0;
    puzzle_sel = 4'(p);
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int off = 1; off <= 400 && !got_done; off++) begin
      wr_ready = bp ? off[0] : 1'b1;
      if (done) begin
        got_done = 1'b1;
        check("done_cycle", off, exp_done);
        check("done_busy", busy, 0);
        check("done_wr_en", wr_en, 0);
      end else begin
        k = p * 81 + n;
        check("load_wr_en", wr_en, 1);
        check("load_busy", busy, 1);
        check("load_addr", wr_addr, n);
        check("load_given", wr_given, ref_given(k));
        check("load_digit", wr_digit, ref_given(k) ? ref_digit(k) : 4'd0);
        if (wr_ready) n++;
      end
      start = poke && (off == 20 || got_done);
      if (poke) puzzle_sel = 4'd2;
      tick();
    end
    start = 1'b0;
    check("write_count", n, 81);
    check("got_done", got_done, 1);
    check("after_done_pulse", done, 0);
    check("after_done_busy", busy, 0);
    check("after_done_wr_en", wr_en, 0);
    check("loaded_idx", loaded_idx, p);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 1215; k++) begin
      maps[4859 - 4 * k -: 4] = ref_digit(k);
      visibilities[1214 - k]  = ref_given(k);
    end
    reset = 1'b1; start = 1'b0; abort = 1'b0; wr_ready = 1'b1; puzzle_sel = 4'd0;
    @(negedge clk);
    tick();
    check_quiet("reset");
    check("reset_loaded_idx", loaded_idx, 0);
    reset = 1'b0;
    tick();

`ifdef RANDOM_PICK_EN
    for (int i = 0; i < 20; i++) begin
      puzzle_sel = 4'(i % 2 == 0 ? 15 : i % 16);
      start = 1'b1;
      tick();
      start = 1'b0;
      check("rand_sel_err", sel_err, 0);
      check("rand_busy", busy, 1);
      check("rand_idx_range", loaded_idx < 4'd15, 1);
      for (int c = 0; c < 99; c++) begin
        if (sel_err) check("rand_sel_err_late", sel_err, 0);
        tick();
      end
      check("rand_idle", busy, 0);
    end
`else
    // 1: plain load of puzzle 0
    run_load(0, 1'b0, 82, 1'b0);

    // 2: backpressure, wr_ready alternating starting high
    run_load(14, 1'b1, 162, 1'b0);
    wr_ready = 1'b1;

    // 3: out-of-range index
    puzzle_sel = 4'd15;
    start = 1'b1;
    tick();
    start = 1'b0;
    check("bad_sel_err", sel_err, 1);
    check("bad_busy", busy, 0);
    check("bad_wr_en", wr_en, 0);
    check("bad_loaded_idx", loaded_idx, 14);
    tick();
    check("bad_sel_err_pulse", sel_err, 0);
    check("bad_busy_later", busy, 0);

    // abort in IDLE, and abort together with start, both do nothing
    abort = 1'b1;
    tick();
    puzzle_sel = 4'd5;
    start = 1'b1;
    tick();
    start = 1'b0;
    abort = 1'b0;
    check_quiet("abort_start_idle");
    check("abort_start_idx", loaded_idx, 14);

    // 4: abort after 10 completed writes
    puzzle_sel = 4'd3;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (10) tick();
    check("abort_addr", wr_addr, 10);
    check("abort_wr_en", wr_en, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_quiet("abort_next");
    for (int c = 0; c < 5; c++) begin
      if (done) check("abort_no_done", done, 0);
      tick();
    end
    run_load(3, 1'b0, 82, 1'b0);

    // 5: start while LOAD and during DONE ignored; then reset at addr 40
    run_load(7, 1'b0, 82, 1'b1);
    puzzle_sel = 4'd9;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (40) tick();
    check("reset_mid_addr", wr_addr, 40);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check_quiet("reset_mid");
    check("reset_mid_idx", loaded_idx, 0);
    for (int c = 0; c < 5; c++) begin
      if (done || wr_en) check("reset_mid_quiet", {done, wr_en}, 0);
      tick();
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
